// File: rtl/cseq_pkg.sv
// Shared types and default widths for the counter sequencer.
// Holds the command opcode encodings and the sequencer FSM state enum.
package cseq_pkg;

  localparam int CSEQ_W  = 4;
  localparam int CSEQ_LW = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_RUN   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/cseq_len_ctr.sv
// Loadable down counter that tracks how many RUN cycles remain.
// It stops at zero and never wraps; zero is decoded from the count.
module cseq_len_ctr
  import cseq_pkg::*;
#(
  parameter int LW = CSEQ_LW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [LW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [LW-1:0] cnt;

  // remaining-cycle register: load wins over decrement, floor at zero
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= {LW{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != {LW{1'b0}})) begin
      cnt <= cnt - {{(LW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == {LW{1'b0}});

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for a 4-bit loadable binary counter (LOAD/RUN/CLEAR).
// Optional feature macro CSEQ_WRAP_STATS_EN adds the wrap_cnt carry statistic.
module counter_sequencer
  import cseq_pkg::*;
#(
  parameter int W  = CSEQ_W,
  parameter int LW = CSEQ_LW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic [LW-1:0] cmd_len,
  input  logic          abort,
  output logic [W-1:0]  ctr_I,
  output logic          ctr_ld,
  output logic          ctr_count,
  output logic          ctr_clr,
  input  logic          ctr_carry,
  input  logic [W-1:0]  ctr_A,
  output logic          done,
  output logic          done_carry,
  output logic [W-1:0]  done_A
`ifdef CSEQ_WRAP_STATS_EN
  ,
  output logic [7:0]    wrap_cnt
`endif
);

  state_t state, state_nxt;
  logic   accept;
  logic   active;
  logic   len_load, len_dec, len_zero;

  assign accept    = cmd_valid && (state == S_IDLE);
  assign active    = (state == S_LOAD) || (state == S_RUN) || (state == S_CLEAR);
  assign cmd_ready = (state == S_IDLE);
  assign ctr_ld    = (state == S_LOAD);
  assign ctr_count = (state == S_RUN);
  assign ctr_clr   = (state == S_CLEAR);
  assign done      = (state == S_DONE);

  // A RUN of length N preloads N-1 so the zero flag marks its final cycle.
  cseq_len_ctr #(.LW(LW)) u_len_ctr (
    .clk      (clk),
    .clr      (clr),
    .load     (len_load),
    .load_val (cmd_len - {{(LW-1){1'b0}}, 1'b1}),
    .dec      (len_dec),
    .zero     (len_zero)
  );

  // next-state decode
  always_comb begin
    state_nxt = state;
    len_load  = 1'b0;
    len_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_LOAD:  state_nxt = S_LOAD;
            OP_CLEAR: state_nxt = S_CLEAR;
            OP_RUN: begin
              if (cmd_len == {LW{1'b0}}) begin
                state_nxt = S_DONE;
              end else begin
                state_nxt = S_RUN;
                len_load  = 1'b1;
              end
            end
            default:  state_nxt = S_IDLE;
          endcase
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LOAD, S_CLEAR: state_nxt = S_DONE;
      S_RUN: begin
        if (abort || len_zero) begin
          state_nxt = S_DONE;
        end else begin
          len_dec = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state, captured load value and completion report
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      ctr_I      <= {W{1'b0}};
      done_carry <= 1'b0;
      done_A     <= {W{1'b0}};
    end else begin
      state <= state_nxt;
      if (accept) begin
        ctr_I      <= cmd_data;
        done_carry <= 1'b0;
      end else if (active && ctr_carry) begin
        done_carry <= 1'b1;
      end else begin
        done_carry <= done_carry;
      end
      if (active) begin
        done_A <= ctr_A;
      end else begin
        done_A <= done_A;
      end
    end
  end

`ifdef CSEQ_WRAP_STATS_EN
  // saturating count of RUN cycles in which the counter wrapped
  always_ff @(posedge clk) begin
    if (clr) begin
      wrap_cnt <= 8'd0;
    end else if ((state == S_RUN) && ctr_carry && (wrap_cnt != 8'hFF)) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end else begin
      wrap_cnt <= wrap_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer with a behavioural binary counter.
// The counter model acts mid-cycle so its value and carry are settled for the sequencer's edge.
module tb_counter_sequencer;
  import cseq_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic [7:0] cmd_len = 8'd0;
  logic       abort = 1'b0;
  logic [3:0] ctr_I;
  logic       ctr_ld, ctr_count, ctr_clr;
  logic       done, done_carry;
  logic [3:0] done_A;
`ifdef CSEQ_WRAP_STATS_EN
  logic [7:0] wrap_cnt;
`endif

  logic [3:0] m_a = 4'h0;
  logic       m_carry = 1'b0;
  int checks = 0;
  int errors = 0;
  int n, lat;

  counter_sequencer dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .abort(abort),
    .ctr_I(ctr_I), .ctr_ld(ctr_ld), .ctr_count(ctr_count), .ctr_clr(ctr_clr),
    .ctr_carry(m_carry), .ctr_A(m_a), .done(done), .done_carry(done_carry),
    .done_A(done_A)
`ifdef CSEQ_WRAP_STATS_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  // binary counter model: clr > ld > count, carry on a counting wrap
  always @(negedge clk) begin
    m_carry <= ctr_count && !ctr_ld && !ctr_clr && (m_a == 4'hF);
    if (ctr_clr)        m_a <= 4'h0;
    else if (ctr_ld)    m_a <= ctr_I;
    else if (ctr_count) m_a <= m_a + 4'h1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  // called in the first cycle after accept; counts count cycles and latency to done
  task automatic wait_done(output int ncount, output int latency);
    ncount  = 0;
    latency = 1;
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      if (ctr_count) ncount++;
      step();
      latency++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    // 1: reset
    step();
    step();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_strobes", {29'd0, ctr_ld, ctr_count, ctr_clr}, 32'd0);
    chk("rst_ctr_I", {28'd0, ctr_I}, 32'd0);
    chk("rst_done", {30'd0, done, done_carry}, 32'd0);
    chk("rst_done_A", {28'd0, done_A}, 32'd0);
`ifdef CSEQ_WRAP_STATS_EN
    chk("rst_wrap", {24'd0, wrap_cnt}, 32'd0);
`endif
    clr = 1'b0;
    step();

    // 2: LOAD 2
    issue(OP_LOAD, 4'b0010, 8'd0);
    chk("load_ld", {29'd0, ctr_ld, ctr_count, ctr_clr}, 32'd4);
    chk("load_I", {28'd0, ctr_I}, 32'd2);
    chk("load_busy", {31'd0, cmd_ready}, 32'd0);
    chk("load_nodone", {31'd0, done}, 32'd0);
    step();
    chk("load_done", {31'd0, done}, 32'd1);
    chk("load_done_A", {28'd0, done_A}, 32'd2);
    chk("load_carry", {31'd0, done_carry}, 32'd0);
    step();
    chk("load_idle", {30'd0, cmd_ready, done}, 32'd2);

    // 3: RUN 5 from 2
    issue(OP_RUN, 4'h0, 8'd5);
    wait_done(n, lat);
    chk("run5_count", n, 32'd5);
    chk("run5_lat", lat, 32'd6);
    chk("run5_done_A", {28'd0, done_A}, 32'd7);
    chk("run5_carry", {31'd0, done_carry}, 32'd0);
    step();

    // 4: LOAD 15 then RUN 1 wraps
    issue(OP_LOAD, 4'b1111, 8'd0);
    wait_done(n, lat);
    chk("load15_lat", lat, 32'd2);
    chk("load15_done_A", {28'd0, done_A}, 32'd15);
    step();
    issue(OP_RUN, 4'h0, 8'd1);
    wait_done(n, lat);
    chk("run1_count", n, 32'd1);
    chk("run1_lat", lat, 32'd2);
    chk("run1_carry", {31'd0, done_carry}, 32'd1);
    chk("run1_done_A", {28'd0, done_A}, 32'd0);
`ifdef CSEQ_WRAP_STATS_EN
    chk("wrap_one", {24'd0, wrap_cnt}, 32'd1);
`endif
    step();

    // 5: RUN 200 aborted in the third count cycle
    issue(OP_RUN, 4'h0, 8'd200);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (ctr_count) n++;
      if (i == 2) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    chk("abort_count", n, 32'd3);
    chk("abort_done", {30'd0, done, ctr_count}, 32'd2);
    chk("abort_done_A", {28'd0, done_A}, 32'd3);
    chk("abort_carry", {31'd0, done_carry}, 32'd0);
    step();
    chk("abort_idle", {31'd0, cmd_ready}, 32'd1);

    // 6a: RUN with length 0
    issue(OP_RUN, 4'h0, 8'd0);
    chk("len0_done", {30'd0, done, ctr_count}, 32'd2);
    step();

    // 6b: NOP is accepted and dropped
    issue(OP_NOP, 4'h5, 8'd3);
    chk("nop_idle", {31'd0, cmd_ready}, 32'd1);
    chk("nop_nodone", {29'd0, done, ctr_ld, ctr_count}, 32'd0);
    step();
    chk("nop_nodone2", {31'd0, done}, 32'd0);

    // 6c: back-to-back CLEAR with cmd_valid held high
    cmd_valid = 1'b1;
    cmd_op    = OP_CLEAR;
    step();
    chk("clr1_strobe", {29'd0, ctr_ld, ctr_count, ctr_clr}, 32'd1);
    chk("clr1_busy", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("clr1_done", {31'd0, done}, 32'd1);
    chk("clr1_done_A", {28'd0, done_A}, 32'd0);
    step();
    chk("b2b_idle", {30'd0, cmd_ready, ctr_clr}, 32'd2);
    step();
    chk("clr2_strobe", {31'd0, ctr_clr}, 32'd1);
    cmd_valid = 1'b0;
    step();
    chk("clr2_done", {31'd0, done}, 32'd1);
    step();

    // 6d: clr in the middle of a RUN
    issue(OP_RUN, 4'h0, 8'd10);
    step();
    chk("mid_run", {31'd0, ctr_count}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("rstrun_idle", {31'd0, cmd_ready}, 32'd1);
    chk("rstrun_out", {28'd0, done, ctr_ld, ctr_count, ctr_clr}, 32'd0);
    chk("rstrun_rep", {27'd0, done_carry, done_A}, 32'd0);
`ifdef CSEQ_WRAP_STATS_EN
    chk("rstrun_wrap", {24'd0, wrap_cnt}, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstrun_nodone", {30'd0, done, ctr_count}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
